latch_write_arbiter: RTL and testbench



---
 rtl/lwa_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/latch_write_arbiter.sv | 154 +++++++++++++++
 tb/tb_latch_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lwa_pkg.sv
// Shared types and constants for the latch write arbiter.
package lwa_pkg;

  // Sequencer states: setup -> enable pulse -> hold around every latch write
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } lwa_state_e;

  // Enable-pulse down-counter width; supports pulse lengths up to 256 cycles
  localparam int unsigned CNT_W = 8;

  // Completed-write counter width (optional feature)
  localparam int unsigned WRCOUNT_W = 16;

endpackage : lwa_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  // Scan NREQ positions starting at ptr; the first hit wins
  always_comb begin
    logic          found;
    logic [IW-1:0] pos;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = IW'((32'(ptr) + k) % NREQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter sequencing writes into a shared bank of D-latch words.
// Each write runs setup (D driven, E low), an enable pulse, then hold, so
// lat_d is stable around every E window. All latch-facing outputs are flops.
// Optional feature: define LWA_WRCOUNT_EN to add a saturating wr_count output.
module latch_write_arbiter
  import lwa_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned NWORDS = 4,
  parameter int unsigned PULSE  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NREQ-1:0]                   req,
  input  logic [NREQ*$clog2(NWORDS)-1:0]    req_addr,
  input  logic [NREQ*DW-1:0]                req_data,
  output logic [NREQ-1:0]                   done,
  output logic [DW-1:0]                     lat_d,
  output logic [NWORDS-1:0]                 lat_e,
  output logic                              busy
`ifdef LWA_WRCOUNT_EN
  ,
  output logic [WRCOUNT_W-1:0]              wr_count
`endif
);

  localparam int unsigned AW = $clog2(NWORDS);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  lwa_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    win_idx;
  logic [NREQ-1:0]  grant;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_data;
  logic             capture;

  logic [IW-1:0]    idx_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    data_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DW-1:0]     lat_d_d;
  logic [NWORDS-1:0] lat_e_d;
  logic [NREQ-1:0]   done_d;
  logic              busy_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx)
  );

  // Select the winning requester's address and data from the packed buses
  always_comb begin
    win_addr = req_addr[win_idx*AW +: AW];
    win_data = req_data[win_idx*DW +: DW];
  end

  assign capture = (state_q == S_IDLE) && (|grant);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|grant) state_d = S_SETUP;
      S_SETUP: state_d = S_PULSE;
      S_PULSE: if (cnt_q == '0) state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Winner capture, rotating pointer and enable-pulse counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      idx_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (capture) begin
        idx_q  <= win_idx;
        addr_q <= win_addr;
        data_q <= win_data;
        ptr_q  <= (32'(win_idx) == NREQ - 1) ? '0 : IW'(32'(win_idx) + 1);
      end
      if (state_q == S_SETUP) begin
        cnt_q <= CNT_W'(PULSE - 1);
      end else if ((state_q == S_PULSE) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Output values for the state being entered, so flops line up with the state
  always_comb begin
    lat_d_d = lat_d;
    lat_e_d = '0;
    done_d  = '0;
    busy_d  = (state_d != S_IDLE);
    if (capture) begin
      lat_d_d = win_data;
    end
    if (state_d == S_PULSE) begin
      lat_e_d[addr_q] = 1'b1;
    end
    if (state_d == S_HOLD) begin
      done_d[idx_q] = 1'b1;
    end
  end

  // Output registers; lat_d only moves on IDLE->SETUP so it holds while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_d <= '0;
      lat_e <= '0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      lat_d <= lat_d_d;
      lat_e <= lat_e_d;
      done  <= done_d;
      busy  <= busy_d;
    end
  end

`ifdef LWA_WRCOUNT_EN
  // Saturating count of completed writes, bumped once per HOLD cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
    end else if ((state_q == S_HOLD) && (wr_count != {WRCOUNT_W{1'b1}})) begin
      wr_count <= wr_count + WRCOUNT_W'(1);
    end
  end
`endif

endmodule : latch_write_arbiter

// File: tb/tb_latch_write_arbiter.sv
// Scoreboard bench for latch_write_arbiter with a behavioural latch bank.
module tb_latch_write_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DW     = 8;
  localparam int unsigned NWORDS = 4;
  localparam int unsigned PULSE  = 2;
  localparam int unsigned AW     = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      done;
  logic [DW-1:0]        lat_d;
  logic [NWORDS-1:0]    lat_e;
  logic                 busy;
`ifdef LWA_WRCOUNT_EN
  logic [15:0]          wr_count;
`endif

  always #5 clk = ~clk;

  latch_write_arbiter #(
    .NREQ   (NREQ),
    .DW     (DW),
    .NWORDS (NWORDS),
    .PULSE  (PULSE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .done     (done),
    .lat_d    (lat_d),
    .lat_e    (lat_e),
    .busy     (busy)
`ifdef LWA_WRCOUNT_EN
    ,
    .wr_count (wr_count)
`endif
  );

  typedef struct {
    int         idx;
    int         addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] want      = '0;
  logic [3:0] done_seen = '0;
  logic       abort     = 1'b0;
  logic [7:0] bank [NWORDS];
  logic [3:0] prev_e = '0;
  logic [7:0] prev_d = '0;
  int         pulse_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input int addr, input logic [7:0] data);
    req_addr[i*AW +: AW] = AW'(addr);
    req_data[i*DW +: DW] = data;
  endtask

  task automatic push(input int i, input int addr, input logic [7:0] data);
    exp_t e;
    e.idx = i; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  // Count done pulses at negedges, bounded; returns elapsed cycles
  task automatic wait_dones(input int n, output int cyc);
    int got;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done != '0) got++;
    end
    chk("done_count_within_budget", got, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Behavioural latch bank: transparent while its enable is high
  always @* begin
    for (int w = 0; w < NWORDS; w++) begin
      if (lat_e[w]) bank[w] = lat_d;
    end
  end

  // Requester model: drop req for the cycle after done, otherwise follow want
  always @(negedge clk) done_seen = done;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      req = want & ~done_seen;
    end
  end

  // Monitor: checks enable pulses and pops the scoreboard on each done
  always @(negedge clk) begin
    if (!rst) begin
      if (lat_e != '0) begin
        if (prev_e == '0) begin
          pulse_len = 1;
          if (exp_q.size() > 0) begin
            chk("enable_word", 32'(lat_e), 32'(1) << exp_q[0].addr);
            chk("setup_data", 32'(prev_d), 32'(exp_q[0].data));
          end
        end else begin
          pulse_len++;
          chk("pulse_data_stable", 32'(lat_d), 32'(prev_d));
        end
      end else if (prev_e != '0 && !abort) begin
        chk("pulse_len", pulse_len, PULSE);
      end
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_onehot", 32'(done), 32'(1) << mon_e.idx);
          chk("done_lat_d", 32'(lat_d), 32'(mon_e.data));
          chk("done_lat_e", 32'(lat_e), 0);
          chk("done_busy", 32'(busy), 1);
          chk("bank_word", 32'(bank[mon_e.addr]), 32'(mon_e.data));
        end
      end
    end
    prev_e = lat_e;
    prev_d = lat_d;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int cnt;
    int nd;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_outputs", {lat_e, done, busy, lat_d}, 0);
    end

    // Single write: requester 2, word 3, A5
    set_req(2, 3, 8'hA5);
    push(2, 3, 8'hA5);
    want = 4'b0100;
    wait_dones(1, cyc);
    want = '0;
    chk("single_latency", cyc, PULSE + 3);
    repeat (2) @(negedge clk);
    chk("single_bank_hold", 32'(bank[3]), 32'hA5);
    chk("lat_d_retained", 32'(lat_d), 32'hA5);
    chk("single_busy_idle", 32'(busy), 0);

    // Round robin with all requesters: 0,1,2,3,0
    do_reset();
    set_req(0, 0, 8'h31);
    set_req(1, 1, 8'h42);
    set_req(2, 2, 8'h53);
    set_req(3, 3, 8'h64);
    push(0, 0, 8'h31);
    push(1, 1, 8'h42);
    push(2, 2, 8'h53);
    push(3, 3, 8'h64);
    push(0, 0, 8'h31);
    want = 4'b1111;
    wait_dones(5, cyc);
    want = '0;
    chk("rr_cycles", cyc, 5 * (PULSE + 3));
    repeat (3) @(negedge clk);
    chk("rr_drained", exp_q.size(), 0);

    // Pointer skip: move ptr to 2, then 0011 grants 0 then 1
    set_req(1, 0, 8'h77);
    push(1, 0, 8'h77);
    want = 4'b0010;
    wait_dones(1, cyc);
    want = '0;
    repeat (2) @(negedge clk);
    set_req(0, 2, 8'h5A);
    set_req(1, 1, 8'hC3);
    push(0, 2, 8'h5A);
    push(1, 1, 8'hC3);
    want = 4'b0011;
    wait_dones(2, cyc);
    want = '0;
    repeat (3) @(negedge clk);
    chk("skip_drained", exp_q.size(), 0);

    // Reset during the first enable-pulse cycle
    set_req(1, 1, 8'h3C);
    push(1, 1, 8'h3C);
    abort = 1'b1;
    want = 4'b0010;
    cnt = 0;
    while (lat_e == '0 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("abort_reached_pulse", 32'(lat_e != '0), 1);
    rst  = 1'b1;
    want = '0;
    @(negedge clk);
    chk("abort_lat_e", 32'(lat_e), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    rst = 1'b0;
    exp_q.delete();
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (done != '0) nd++;
    end
    chk("abort_no_done", nd, 0);
    abort = 1'b0;

    // Pointer back at 0 after reset: 0110 must grant requester 1
    set_req(1, 3, 8'h96);
    set_req(2, 2, 8'h69);
    push(1, 3, 8'h96);
    want = 4'b0110;
    wait_dones(1, cyc);
    want = '0;
    repeat (3) @(negedge clk);
    chk("ptr_reset_drained", exp_q.size(), 0);

`ifdef LWA_WRCOUNT_EN
    do_reset();
    chk("wrcount_reset", 32'(wr_count), 0);
    set_req(0, 0, 8'h01);
    repeat (3) push(0, 0, 8'h01);
    want = 4'b0001;
    wait_dones(3, cyc);
    want = '0;
    @(negedge clk);
    chk("wrcount_three", 32'(wr_count), 3);
    force dut.wr_count = 16'hFFFE;
    @(negedge clk);
    release dut.wr_count;
    repeat (3) push(0, 0, 8'h01);
    want = 4'b0001;
    wait_dones(3, cyc);
    want = '0;
    @(negedge clk);
    chk("wrcount_saturate", 32'(wr_count), 32'hFFFF);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_latch_write_arbiter
